mul_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one registered unsigned multiplier among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, launches its operands into the shared multiplier, and returns the product tagged with the requester index through a valid/ready response port. It sits between the multiplier datapath and the client logic that needs products.

---
 rtl/mul_share_arb_pkg.sv | 47 ++++
 rtl/mul_share_arb_mul_core.sv | 23 ++
 rtl/mul_share_arb.sv | 119 +++++++++++
 tb/tb_mul_share_arb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_arb_pkg.sv
// mul_share_arb_pkg
// Shared types, default widths and the round-robin pick helper for
// mul_share_arb.
//   arb_state_t : controller states (IDLE, BUSY, DONE)
//   rr_pick_t   : pick result {found, idx}
//   rr_pick()   : searches valid[] starting at (last+1) mod n, wrapping
`timescale 1ns/1ps
package mul_share_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_A_W     = 4;
    localparam int DEF_B_W     = 4;

    // The helper works on a fixed maximum width so one function
    // serves every legal NUM_REQ (2..8).
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [IDX_W-1:0]   last,
                                         input int                 n);
        rr_pick_t r;
        int       idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = (int'(last) + k) % n;
            if (k <= n && !r.found && valid[idx[IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_share_arb_mul_core.sv
// mul_core
// Registered unsigned multiplier shared by all requesters.
//   clk : clock
//   a   : operand A (A_W)
//   b   : operand B (B_W)
//   c   : a*b registered every posedge, full A_W+B_W width
// No reset and no enable: the controller gates the operands.
`timescale 1ns/1ps
module mul_core #(
    parameter int A_W = 4,
    parameter int B_W = 4
) (
    input  logic               clk,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] c
);

    always_ff @(posedge clk) begin
        c <= (A_W+B_W)'(a) * (A_W+B_W)'(b);
    end

endmodule

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Round-robin arbiter/sequencer sharing one registered multiplier among
// NUM_REQ requesters. One operation in flight: IDLE (grant) -> BUSY
// (product settles) -> DONE (response held until accepted).
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake, ready is one-hot grant
//   req_a, req_b      : packed operands, requester i at [i*W +: W]
//   rsp_valid/ready   : response handshake
//   rsp_id, rsp_c     : requester index and unsigned product
//   busy              : state is not IDLE
// Optional: MUL_SHARE_ARB_PRIO_EN gives requester 0 fixed top priority;
// the others round-robin and requester-0 grants leave `last` untouched.
`timescale 1ns/1ps
module mul_share_arb
    import mul_share_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int A_W     = DEF_A_W,
    parameter  int B_W     = DEF_B_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ*B_W-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [A_W+B_W-1:0]     rsp_c,
    output logic                   busy
);

    arb_state_t           state, state_nxt;
    logic [ID_W-1:0]      last;
    logic [ID_W-1:0]      sel;
    logic                 grant;
    rr_pick_t             pick;
    logic [MAX_REQ-1:0]   valid_ext;
    logic [A_W-1:0]       mul_a;
    logic [B_W-1:0]       mul_b;
    logic [A_W+B_W-1:0]   mul_c;

    assign valid_ext = MAX_REQ'(req_valid);

`ifdef MUL_SHARE_ARB_PRIO_EN
    always_comb begin
        if (req_valid[0]) begin
            pick.found = 1'b1;
            pick.idx   = '0;
        end else begin
            // Requester 0 is excluded from the rotation.
            pick = rr_pick(valid_ext & ~MAX_REQ'(1), IDX_W'(last), NUM_REQ);
        end
    end
`else
    always_comb begin
        pick = rr_pick(valid_ext, IDX_W'(last), NUM_REQ);
    end
`endif

    assign sel   = pick.idx[ID_W-1:0];
    // Reset holds req_ready low so nothing is accepted during reset.
    assign grant = (state == IDLE) && pick.found && !rst;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grant) begin
            req_ready = NUM_REQ'(1) << sel;
            mul_a     = req_a[int'(sel)*A_W +: A_W];
            mul_b     = req_b[int'(sel)*B_W +: B_W];
        end
    end

    mul_core #(.A_W(A_W), .B_W(B_W)) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .c   (mul_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = BUSY;
            BUSY:    state_nxt = DONE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last   <= ID_W'(NUM_REQ-1);
            rsp_id <= '0;
            rsp_c  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                rsp_id <= sel;
`ifdef MUL_SHARE_ARB_PRIO_EN
                if (sel != '0) last <= sel;
`else
                last <= sel;
`endif
            end
            // Multiplier output holds the granted product during BUSY.
            if (state == BUSY) rsp_c <= mul_c;
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
`timescale 1ns/1ps
module tb_mul_share_arb;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int BW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [AW+BW-1:0] rsp_c;
    logic            busy;

    logic [AW-1:0] opa [N];
    logic [BW-1:0] opb [N];
    logic [N-1:0]  vmask;
    int tests = 0;
    int fails = 0;
    int mlast;          // reference round-robin pointer

    mul_share_arb #(.NUM_REQ(N), .A_W(AW), .B_W(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = opa[i];
            req_b[i*BW +: BW] = opb[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Who should win: scan forward from the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] m);
`ifdef MUL_SHARE_ARB_PRIO_EN
        if (m[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (mlast + k) % N;
`ifdef MUL_SHARE_ARB_PRIO_EN
            if (i == 0) continue;
`endif
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_commit(input int g);
`ifdef MUL_SHARE_ARB_PRIO_EN
        if (g != 0) mlast = g;
`else
        mlast = g;
`endif
    endfunction

    task automatic raise(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        if (!vmask[i]) begin
            opa[i]   = a;
            opb[i]   = b;
            vmask[i] = 1'b1;
        end
    endtask

    // Entered just after a negedge with the DUT in IDLE; runs one full
    // grant -> busy -> response sequence, holding rsp_ready low `hold` cycles.
    task automatic do_op(input int hold);
        int g;
        int exp_c;
        req_valid = vmask;
        rsp_ready = 1'b0;
        #1;
        g = model_pick(vmask);
        if (g < 0) begin
            chk("no_pending_request", 32'(vmask), 32'hFFFF_FFFF);
            return;
        end
        exp_c = int'(opa[g]) * int'(opb[g]);
        chk("grant_onehot", 32'(req_ready), 32'(1) << g);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        model_commit(g);
        @(negedge clk);
        vmask[g]  = 1'b0;
        req_valid = vmask;
        #1;
        chk("busy_busy", 32'(busy), 1);
        chk("busy_rsp_valid", 32'(rsp_valid), 0);
        chk("busy_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("done_rsp_valid", 32'(rsp_valid), 1);
        chk("done_rsp_c", 32'(rsp_c), 32'(exp_c));
        chk("done_rsp_id", 32'(rsp_id), 32'(g));
        chk("done_busy", 32'(busy), 1);
        chk("done_req_ready", 32'(req_ready), 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_rsp_valid", 32'(rsp_valid), 1);
            chk("hold_rsp_c", 32'(rsp_c), 32'(exp_c));
            chk("hold_rsp_id", 32'(rsp_id), 32'(g));
            chk("hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
    endtask

    task automatic drain();
        for (int n = 0; n < 2*N && vmask != '0; n++) begin
            @(negedge clk);
            do_op(0);
        end
    endtask

    initial begin
        int g;
        rst       = 1'b1;
        vmask     = '0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        mlast = N-1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_c", 32'(rsp_c), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;

        // Nothing valid: stays idle.
        @(negedge clk);
        #1;
        chk("idle_no_req_ready", 32'(req_ready), 0);
        chk("idle_no_req_busy", 32'(busy), 0);

        // All four contending, a=i+1, b=3: order 0,1,2,3 back to back.
        @(negedge clk);
        for (int i = 0; i < N; i++) raise(i, AW'(i+1), BW'(3));
        do_op(0);
        for (int i = 1; i < N; i++) begin
            @(negedge clk);
            do_op(0);
        end

        // Single request from requester 2: 5*5.
        @(negedge clk);
        raise(2, 4'd5, 4'd5);
        do_op(0);

        // Backpressure with other requests waiting.
        @(negedge clk);
        raise(0, 4'd7, 4'd2);
        raise(1, 4'd3, 4'd11);
        raise(3, 4'd9, 4'd9);
        do_op(5);
        drain();

        // Boundary operands.
        @(negedge clk);
        raise(1, 4'd15, 4'd15);
        do_op(0);
        @(negedge clk);
        raise(3, 4'd0, 4'd9);
        do_op(0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1) raise(i, AW'($urandom), BW'($urandom));
            if (vmask == '0) raise(int'($urandom_range(0, N-1)), AW'($urandom), BW'($urandom));
            do_op(int'($urandom_range(0, 2)));
        end
        drain();

`ifdef MUL_SHARE_ARB_PRIO_EN
        // Requester 0 always wins while valid.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            raise(0, AW'($urandom), BW'($urandom));
            raise(1, AW'($urandom), BW'($urandom));
            raise(3, AW'($urandom), BW'($urandom));
            do_op(0);
        end
        // Without requester 0, the others alternate.
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            raise(1, AW'($urandom), BW'($urandom));
            raise(3, AW'($urandom), BW'($urandom));
            do_op(0);
        end
        drain();
`endif

        // Reset while BUSY: request dropped, pointer back to reset value.
        @(negedge clk);
        raise(0, 4'd6, 4'd7);
        raise(1, 4'd2, 4'd13);
        raise(3, 4'd12, 4'd4);
        req_valid = vmask;
        rsp_ready = 1'b0;
        #1;
        g = model_pick(vmask);
        chk("rstop_grant", 32'(req_ready), 32'(1) << g);
        @(negedge clk);
        vmask[g]  = 1'b0;
        req_valid = vmask;
        rst       = 1'b1;
        #1;
        chk("rstop_busy", 32'(busy), 1);
        @(negedge clk);
        #1;
        chk("rstop_req_ready", 32'(req_ready), 0);
        chk("rstop_rsp_valid", 32'(rsp_valid), 0);
        chk("rstop_rsp_id", 32'(rsp_id), 0);
        chk("rstop_rsp_c", 32'(rsp_c), 0);
        chk("rstop_busy_low", 32'(busy), 0);
        mlast = N-1;
        rst   = 1'b0;
        do_op(0);
        drain();

        @(negedge clk);
        #1;
        chk("final_idle_busy", 32'(busy), 0);
        chk("final_idle_rsp_valid", 32'(rsp_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
